calc_seq_ctrl: RTL

//  Sequencer for the calculator datapath (A/B operand regs, add/sub unit, result reg R, output unit).

---
 rtl/calc_seq_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: enter-stepped sequencer for the calculator datapath (load A, load B, compute, show).
// Build option CALC_MUL_EN adds the shift-add multiply (op 10); without it op 10 is reserved -> ERR.
module calc_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       enter,
   input  logic [1:0] op,
   input  logic       b_lsb,
   output logic       LdA,
   output logic       LdB,
   output logic       LdR,
   output logic       ClrR,
   output logic       AddSub,
   output logic       ShAB,
   output logic       LdOU,
   output logic       IUAU,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] LED
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [3:0] {
      IDLE,
      CAP_A,
      WAIT_B,
      CAP_B,
      EXEC,
`ifdef CALC_MUL_EN
      MUL_CLR,
      MUL_ADD,
      MUL_SHF,
`endif
      SHOW,
      ERR
   } state_t;

   state_t state, state_nxt;
   logic   sync_p0, sync_p1, prev_p2;
   logic   ent_p;
   logic   in_show_q;
   logic   sub_q;

   // enter front end: two-flop synchroniser, then rising-edge detect
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         prev_p2 <= 1'b0;
      end else begin
         sync_p0 <= enter;
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
      end
   end

   assign ent_p = sync_p1 & ~prev_p2;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state     <= IDLE;
         in_show_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_show_q <= (state == SHOW);
      end
   end

   // operation select is datapath-like and needs no reset; only add/sub polarity is kept
   always_ff @(posedge clock) begin
      if (state == CAP_B)
         sub_q <= op[0];
   end

`ifdef CALC_MUL_EN
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clock or posedge clear) begin
      if (clear)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end
`else
   logic unused_b_lsb;
   assign unused_b_lsb = b_lsb;
`endif

   assign done = (state == SHOW) && !in_show_q;

   always_comb begin
      state_nxt = state;
`ifdef CALC_MUL_EN
      cnt_nxt   = cnt;
`endif
      LdA    = 1'b0;
      LdB    = 1'b0;
      LdR    = 1'b0;
      ClrR   = 1'b0;
      AddSub = 1'b0;
      ShAB   = 1'b0;
      LdOU   = 1'b0;
      IUAU   = 1'b0;
      busy   = 1'b0;
      err    = 1'b0;
      LED    = 2'd0;
      unique case (state)
         IDLE: begin
            IUAU = 1'b1;
            if (ent_p)
               state_nxt = CAP_A;
         end
         CAP_A: begin
            LdA       = 1'b1;
            LdOU      = 1'b1;
            state_nxt = WAIT_B;
         end
         WAIT_B: begin
            IUAU = 1'b1;
            LdOU = 1'b1;
            LED  = 2'd1;
            if (ent_p)
               state_nxt = CAP_B;
         end
         CAP_B: begin
            LdB  = 1'b1;
            busy = 1'b1;
            LED  = 2'd1;
            unique case (op)
               2'b00, 2'b01: state_nxt = EXEC;
`ifdef CALC_MUL_EN
               2'b10:        state_nxt = MUL_CLR;
`endif
               default:      state_nxt = ERR;
            endcase
         end
         EXEC: begin
            LdR       = 1'b1;
            AddSub    = sub_q;
            busy      = 1'b1;
            LED       = 2'd2;
            state_nxt = SHOW;
         end
`ifdef CALC_MUL_EN
         MUL_CLR: begin
            ClrR      = 1'b1;
            busy      = 1'b1;
            LED       = 2'd2;
            cnt_nxt   = '0;
            state_nxt = MUL_ADD;
         end
         MUL_ADD: begin
            LdR       = b_lsb;
            busy      = 1'b1;
            LED       = 2'd2;
            state_nxt = MUL_SHF;
         end
         // exit on the last iteration so the counter never wraps
         MUL_SHF: begin
            ShAB = 1'b1;
            busy = 1'b1;
            LED  = 2'd2;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_nxt = SHOW;
            end else begin
               cnt_nxt   = cnt + 1'b1;
               state_nxt = MUL_ADD;
            end
         end
`endif
         SHOW: begin
            LdOU = 1'b1;
            LED  = 2'd3;
            if (ent_p)
               state_nxt = IDLE;
         end
         ERR: begin
            err  = 1'b1;
            IUAU = 1'b1;
            LED  = 2'd3;
            if (ent_p)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
